// File: rtl/spi_master.sv
// SPI mode-0 master for SD cards: shifts out a 40-bit command frame, then polls
// response bytes until one arrives with bit 7 clear or NCR_MAX bytes have passed.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int NCR_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [39:0] data_in_i,
    input  logic        miso_i,
    output logic        mosi_o,
    output logic        sck_o,
    output logic [7:0]  data_out_o,
    output logic        busy_o,
    output logic        new_data_o
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BYTE_W = $clog2(NCR_MAX + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_t;

    state_t            state_q;
    logic [DIV_W-1:0]  div_q;
    logic [5:0]        bit_q;
    logic [BYTE_W-1:0] byte_q;
    logic [39:0]       shift_q;
    logic [7:0]        rx_q;

    logic              tick_d;
    logic [BYTE_W-1:0] byte_d;

    assign tick_d = (div_q == DIV_W'(CLK_DIV - 1));
    assign byte_d = byte_q + BYTE_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            mosi_o     <= 1'b1;
            sck_o      <= 1'b0;
            busy_o     <= 1'b0;
            new_data_o <= 1'b0;
            data_out_o <= 8'hFF;
        end else begin
            new_data_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    sck_o  <= 1'b0;
                    mosi_o <= 1'b1;
                    if (start_i) begin
                        shift_q <= data_in_i;
                        mosi_o  <= data_in_i[39];
                        busy_o  <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                        byte_q  <= '0;
                        state_q <= SEND;
                    end
                end
                SEND, WAIT_RESP: begin
                    if (!tick_d) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        sck_o <= ~sck_o;
                        if (!sck_o) begin
                            // Rising edge: sample; command-phase samples are simply overwritten later.
                            rx_q <= {rx_q[6:0], miso_i};
                        end else if (state_q == SEND) begin
                            // Falling edge: bit boundary, present the next frame bit.
                            shift_q <= {shift_q[38:0], 1'b1};
                            mosi_o  <= shift_q[38];
                            bit_q   <= bit_q + 6'd1;
                            if (bit_q == 6'd39) begin
                                bit_q   <= '0;
                                mosi_o  <= 1'b1;
                                state_q <= WAIT_RESP;
                            end
                        end else begin
                            bit_q <= bit_q + 6'd1;
                            if (bit_q == 6'd7) begin
                                bit_q  <= '0;
                                byte_q <= byte_d;
                                if (!rx_q[7] || byte_d == BYTE_W'(NCR_MAX)) begin
                                    data_out_o <= rx_q[7] ? 8'hFF : rx_q;
                                    new_data_o <= 1'b1;
                                    busy_o     <= 1'b0;
                                    mosi_o     <= 1'b1;
                                    state_q    <= DONE;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance with CLK_DIV=4 and one with CLK_DIV=1,
// each driven by a small SD-card miso model that replays a table of response bytes.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [2];
    logic [39:0] din   [2];
    logic        miso  [2];
    logic        mosi  [2];
    logic        sck   [2];
    logic [7:0]  dout  [2];
    logic        busy  [2];
    logic        nd    [2];

    int          pass_cnt  = 0;
    int          total_cnt = 0;

    // Card model state and observation
    logic [7:0]  resp     [2][3];
    int          nresp    [2];
    int          base     [2];
    int          rises    [2];
    int          unstable [2];
    int          nd_cnt   [2];
    logic [47:0] cap      [2];
    logic        prev_sck [2];
    logic        prev_mosi[2];

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4), .NCR_MAX(8)) u_div4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .data_in_i(din[0]),
        .miso_i(miso[0]), .mosi_o(mosi[0]), .sck_o(sck[0]), .data_out_o(dout[0]),
        .busy_o(busy[0]), .new_data_o(nd[0])
    );

    spi_master #(.CLK_DIV(1), .NCR_MAX(8)) u_div1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .data_in_i(din[1]),
        .miso_i(miso[1]), .mosi_o(mosi[1]), .sck_o(sck[1]), .data_out_o(dout[1]),
        .busy_o(busy[1]), .new_data_o(nd[1])
    );

    // Monitor: records mosi at every sck rise and sets miso for the next rise.
    always begin
        int idx;
        int j;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (sck[d] && !prev_sck[d]) begin
                if (mosi[d] !== prev_mosi[d]) unstable[d]++;
                cap[d] = {cap[d][46:0], mosi[d]};
                rises[d]++;
            end
            idx = rises[d] - base[d] - 40;
            j   = idx / 8;
            if (idx < 0 || j >= nresp[d] || j >= 3) miso[d] = 1'b1;
            else miso[d] = resp[d][j][7 - (idx % 8)];
            if (nd[d]) nd_cnt[d]++;
            prev_sck[d]  = sck[d];
            prev_mosi[d] = mosi[d];
        end
    end

    task automatic start_txn(input int d, input logic [39:0] f, input logic [7:0] r0,
                             input logic [7:0] r1, input logic [7:0] r2, input int n);
        @(negedge clk);
        din[d]     = f;
        resp[d][0] = r0;
        resp[d][1] = r1;
        resp[d][2] = r2;
        nresp[d]   = n;
        base[d]    = rises[d];
        start[d]   = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    // Counts cycles from the start edge E until new_data is seen (bounded).
    task automatic wait_done(input int d, output int cyc, output int blen, output int frise);
        cyc   = 0;
        blen  = busy[d] ? 1 : 0;
        frise = -1;
        while (!nd[d] && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy[d]) blen++;
            if (frise < 0 && sck[d]) frise = cyc;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            din[d]   = '0;
            nresp[d] = 0;
            base[d]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (mosi[0] !== 1'b1) $display("FAIL reset_mosi got %b want 1", mosi[0]); else pass_cnt++;
        total_cnt++; if (sck[0] !== 1'b0) $display("FAIL reset_sck got %b want 0", sck[0]); else pass_cnt++;
        total_cnt++; if (busy[0] !== 1'b0) $display("FAIL reset_busy got %b want 0", busy[0]); else pass_cnt++;
        total_cnt++; if (nd[0] !== 1'b0) $display("FAIL reset_new_data got %b want 0", nd[0]); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'hFF) $display("FAIL reset_data_out got %h want ff", dout[0]); else pass_cnt++;
        total_cnt++; if (dout[1] !== 8'hFF) $display("FAIL reset_data_out_div1 got %h want ff", dout[1]); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_cmd0();
        int cyc, blen, frise;
        start_txn(0, 40'h4000000095, 8'h01, 8'hFF, 8'hFF, 1);
        wait_done(0, cyc, blen, frise);
        total_cnt++; if (cyc !== 384) $display("FAIL cmd0_new_data_time got %0d want 384", cyc); else pass_cnt++;
        total_cnt++; if (blen !== 384) $display("FAIL cmd0_busy_len got %0d want 384", blen); else pass_cnt++;
        total_cnt++; if (frise !== 4) $display("FAIL cmd0_first_rise got %0d want 4", frise); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'h01) $display("FAIL cmd0_data_out got %h want 01", dout[0]); else pass_cnt++;
        total_cnt++; if (cap[0] !== {40'h4000000095, 8'hFF}) $display("FAIL cmd0_mosi_frame got %h want %h", cap[0], {40'h4000000095, 8'hFF}); else pass_cnt++;
        total_cnt++; if (rises[0] - base[0] !== 48) $display("FAIL cmd0_sck_rises got %0d want 48", rises[0] - base[0]); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (nd[0] !== 1'b0) $display("FAIL cmd0_pulse_width got %b want 0", nd[0]); else pass_cnt++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_delayed();
        int cyc, blen, frise;
        start_txn(0, 40'h5100000000, 8'hFF, 8'hFF, 8'h05, 3);
        wait_done(0, cyc, blen, frise);
        total_cnt++; if (cyc !== 512) $display("FAIL delayed_time got %0d want 512", cyc); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'h05) $display("FAIL delayed_data_out got %h want 05", dout[0]); else pass_cnt++;
        total_cnt++; if (rises[0] - base[0] !== 64) $display("FAIL delayed_sck_rises got %0d want 64", rises[0] - base[0]); else pass_cnt++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_timeout();
        int cyc, blen, frise;
        start_txn(0, 40'h4000000095, 8'hFF, 8'hFF, 8'hFF, 0);
        wait_done(0, cyc, blen, frise);
        total_cnt++; if (cyc !== 832) $display("FAIL timeout_time got %0d want 832", cyc); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'hFF) $display("FAIL timeout_data_out got %h want ff", dout[0]); else pass_cnt++;
        total_cnt++; if (busy[0] !== 1'b0) $display("FAIL timeout_busy_drop got %b want 0", busy[0]); else pass_cnt++;
        total_cnt++; if (blen !== 832) $display("FAIL timeout_busy_len got %0d want 832", blen); else pass_cnt++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, blen, frise;
        start_txn(0, 40'h4000000095, 8'h01, 8'hFF, 8'hFF, 1);
        cyc = 0;
        while (!nd[0] && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 100) begin
                start[0] = 1'b1;
                din[0]   = 40'h7700AA5501;
            end else if (cyc == 101) begin
                start[0] = 1'b0;
            end
        end
        total_cnt++; if (cyc !== 384) $display("FAIL lockout_time got %0d want 384", cyc); else pass_cnt++;
        total_cnt++; if (cap[0] !== {40'h4000000095, 8'hFF}) $display("FAIL lockout_frame got %h want %h", cap[0], {40'h4000000095, 8'hFF}); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'h01) $display("FAIL lockout_data_out got %h want 01", dout[0]); else pass_cnt++;
        // start held from the DONE cycle: refused there, accepted the cycle after
        din[0]     = 40'h48000001AA;
        resp[0][0] = 8'h00;
        nresp[0]   = 1;
        base[0]    = rises[0];
        start[0]   = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if (busy[0] !== 1'b0) $display("FAIL b2b_gap_busy got %b want 0", busy[0]); else pass_cnt++;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        total_cnt++; if (busy[0] !== 1'b1) $display("FAIL b2b_accept_busy got %b want 1", busy[0]); else pass_cnt++;
        wait_done(0, cyc, blen, frise);
        total_cnt++; if (cyc !== 384) $display("FAIL b2b_time got %0d want 384", cyc); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'h00) $display("FAIL b2b_data_out got %h want 00", dout[0]); else pass_cnt++;
        total_cnt++; if (cap[0] !== {40'h48000001AA, 8'hFF}) $display("FAIL b2b_frame got %h want %h", cap[0], {40'h48000001AA, 8'hFF}); else pass_cnt++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_divider();
        int cyc, blen, frise, unst0;
        unst0 = unstable[1];
        start_txn(1, 40'h4000000095, 8'h01, 8'hFF, 8'hFF, 1);
        total_cnt++; if (sck[1] !== 1'b0) $display("FAIL div1_sck_at_start got %b want 0", sck[1]); else pass_cnt++;
        wait_done(1, cyc, blen, frise);
        total_cnt++; if (frise !== 1) $display("FAIL div1_first_rise got %0d want 1", frise); else pass_cnt++;
        total_cnt++; if (cyc !== 96) $display("FAIL div1_time got %0d want 96", cyc); else pass_cnt++;
        total_cnt++; if (blen !== 96) $display("FAIL div1_busy_len got %0d want 96", blen); else pass_cnt++;
        total_cnt++; if (dout[1] !== 8'h01) $display("FAIL div1_data_out got %h want 01", dout[1]); else pass_cnt++;
        total_cnt++; if (cap[1] !== {40'h4000000095, 8'hFF}) $display("FAIL div1_frame got %h want %h", cap[1], {40'h4000000095, 8'hFF}); else pass_cnt++;
        total_cnt++; if (unstable[1] !== unst0) $display("FAIL div1_mosi_stable got %0d want %0d", unstable[1], unst0); else pass_cnt++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int nd0;
        start_txn(0, 40'h4000000095, 8'h01, 8'hFF, 8'hFF, 1);
        repeat (101) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (mosi[0] !== 1'b1) $display("FAIL midrst_mosi got %b want 1", mosi[0]); else pass_cnt++;
        total_cnt++; if (sck[0] !== 1'b0) $display("FAIL midrst_sck got %b want 0", sck[0]); else pass_cnt++;
        total_cnt++; if (busy[0] !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy[0]); else pass_cnt++;
        total_cnt++; if (nd[0] !== 1'b0) $display("FAIL midrst_new_data got %b want 0", nd[0]); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'hFF) $display("FAIL midrst_data_out got %h want ff", dout[0]); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        nd0 = nd_cnt[0];
        repeat (900) @(posedge clk);
        #1;
        total_cnt++; if (nd_cnt[0] !== nd0) $display("FAIL midrst_no_pulse got %0d want %0d", nd_cnt[0], nd0); else pass_cnt++;
        total_cnt++; if (busy[0] !== 1'b0) $display("FAIL midrst_idle_busy got %b want 0", busy[0]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_delayed();
        test_timeout();
        test_back_to_back();
        test_divider();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
